// File: rtl/dm_req_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// Both channels use valid/ready: a transfer happens on the rising edge where valid && ready.
interface dm_req_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_req_responder.sv
// Multi-cycle handshaked word data memory: one outstanding load/store, fixed LATENCY to response.
// Words are stored big-endian, so the byte at a word-aligned address lives in bits [31:24].
module dm_req_responder #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    dm_req_responder_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int         WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                accept;
    logic                misaligned;
    logic [ADDR_W-3:0]   word_idx;
    logic [DATA_W-1:0]   mem [WORDS];
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    assign misaligned = (bus.req_addr[1:0] != 2'b00);
    assign word_idx   = bus.req_addr[ADDR_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // req_ready is held low while rst is asserted even though the state is already IDLE.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = ~rst;
                accept        = bus.req_valid & ~rst;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load data is captured at accept, so the response is immune to later memory changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
            if (misaligned) begin
                rdata_q <= '0;
            end else if (bus.req_write) begin
                mem[word_idx] <= bus.req_wdata;
                rdata_q       <= '0;
            end else begin
                rdata_q <= mem[word_idx];
            end
        end else if (state == RESP && bus.resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_dm_req_responder.sv
// Drives three responders (LATENCY 2, 1, 15) against a word-array reference memory with
// an expected-response queue.
module tb_dm_req_responder;
    logic clk;
    logic rst;

    logic [2:0]       req_valid;
    logic [2:0]       req_write;
    logic [2:0][6:0]  req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0]       resp_ready;
    logic [2:0]       req_ready;
    logic [2:0]       resp_valid;
    logic [2:0][31:0] resp_rdata;
    logic [2:0]       resp_err;
    logic [2:0][1:0]  dbg_state;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        dm_req_responder_if #(.ADDR_W(7), .DATA_W(32)) bus ();
        dm_req_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus.slave),
            .dbg_state (dbg_state[g])
        );
        assign bus.req_valid  = req_valid[g];
        assign bus.req_write  = req_write[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.resp_ready = resp_ready[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [3][32];
    logic [32:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 32; w++) model_mem[k][w] = 32'h0;
    endtask

    // One request on responder k; hold = cycles of backpressure in RESP, early = resp_ready
    // raised right after accept (ignored by the responder until RESP).
    task automatic xact(input int k, input logic wr, input logic [6:0] addr,
                        input logic [31:0] wd, input int hold, input logic early);
        int          n;
        logic [32:0] e;
        logic [31:0] rd0;
        logic        er0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", (n < 50), 1);
        if (addr[1:0] != 2'b00)
            e = {1'b1, 32'h0};
        else if (wr) begin
            model_mem[k][addr[6:2]] = wd;
            e = {1'b0, 32'h0};
        end else
            e = {1'b0, model_mem[k][addr[6:2]]};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_wdata[k] = $urandom;
        if (early) resp_ready[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[k] && n < 40);
        chk("latency", n, lat_of(k));
        rd0 = resp_rdata[k];
        er0 = resp_err[k];
        for (int i = 0; i < hold; i++) begin
            chk("hold_req_ready", req_ready[k], 0);
            if (i == 0) begin
                // A stray store that must be ignored; accepting it would corrupt word 0.
                req_valid[k] = 1'b1;
                req_write[k] = 1'b1;
                req_addr[k]  = 7'h00;
                req_wdata[k] = ~model_mem[k][0];
            end
            @(negedge clk);
            chk("hold_valid", resp_valid[k], 1);
            chk("hold_rdata", resp_rdata[k], rd0);
            chk("hold_err", resp_err[k], er0);
        end
        req_valid[k] = 1'b0;
        e = exp_q.pop_front();
        chk("rdata", resp_rdata[k], e[31:0]);
        chk("err", resp_err[k], e[32]);
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[k] = 1'b0;
    endtask

    // Continuous loads of word 0x08 with resp_ready held high: one accept per LATENCY+1 cycles.
    task automatic b2b(input int k);
        int          lat, acc, resp, last;
        logic [31:0] ev;
        lat  = lat_of(k);
        ev   = model_mem[k][2];
        acc  = 0;
        resp = 0;
        last = 0;
        @(negedge clk);
        req_valid[k]  = 1'b1;
        req_write[k]  = 1'b0;
        req_addr[k]   = 7'h08;
        resp_ready[k] = 1'b1;
        for (int c = 0; c < 4 * (lat + 1); c++) begin
            if (req_ready[k]) begin
                if (acc > 0) chk("b2b_gap", c - last, lat + 1);
                last = c;
                acc++;
            end
            if (resp_valid[k]) begin
                resp++;
                chk("b2b_rdata", resp_rdata[k], ev);
            end
            @(negedge clk);
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b0;
        chk("b2b_accepts", acc, 4);
        chk("b2b_resps", resp, 4);
    endtask

    initial begin
        int          n;
        logic [6:0]  a;
        logic        wr;
        int          hold;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '0;
        rst        = 1'b1;
        clear_model();

        // Reset held two cycles
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 3'b000);
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_rdata0", resp_rdata[0], 0);
        chk("rst_err", resp_err, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 3'b111);
        for (int k = 0; k < 3; k++) xact(k, 1'b0, 7'h10, 32'h0, 0, 1'b0);

        // Store/load, misaligned store, backpressure
        xact(0, 1'b1, 7'h08, 32'hDEADBEEF, 0, 1'b0);
        xact(0, 1'b0, 7'h08, 32'h0, 0, 1'b0);
        xact(0, 1'b1, 7'h0A, 32'h12345678, 0, 1'b0);
        xact(0, 1'b0, 7'h08, 32'h0, 0, 1'b0);
        xact(0, 1'b0, 7'h08, 32'h0, 5, 1'b0);
        xact(0, 1'b0, 7'h00, 32'h0, 0, 1'b0);
        xact(0, 1'b1, 7'h09, 32'hFFFFFFFF, 2, 1'b0);

        // Top and bottom words are distinct
        for (int k = 0; k < 3; k += 2) begin
            xact(k, 1'b1, 7'h7C, 32'hAAAA5555, 0, 1'b0);
            xact(k, 1'b1, 7'h00, 32'h11223344, 0, 1'b0);
            xact(k, 1'b0, 7'h7C, 32'h0, 0, 1'b0);
            xact(k, 1'b0, 7'h00, 32'h0, 0, 1'b0);
        end

        for (int k = 0; k < 3; k++) xact(k, 1'b1, 7'h08, 32'h0BADF00D ^ k, 0, 1'b0);
        for (int k = 0; k < 3; k++) b2b(k);

        // Randomized traffic
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                a = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                wr   = 1'($urandom_range(0, 1));
                hold = $urandom_range(0, 3);
                xact(k, wr, a, $urandom, hold, (hold == 0) && ($urandom_range(0, 1) == 1));
            end
        end

        // Reset while a load is in flight on the LATENCY=15 responder
        xact(2, 1'b1, 7'h20, 32'hCAFEF00D, 0, 1'b0);
        xact(0, 1'b1, 7'h20, 32'h5A5A5A5A, 0, 1'b0);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2]  = 7'h20;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midop_in_wait", {resp_valid[2], req_ready[2]}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        chk("midop_idle", req_ready, 3'b111);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid[2]) n++;
            @(negedge clk);
        end
        chk("midop_no_resp", n, 0);
        xact(2, 1'b0, 7'h20, 32'h0, 0, 1'b0);
        xact(0, 1'b0, 7'h20, 32'h0, 0, 1'b0);
        xact(0, 1'b0, 7'h08, 32'h0, 0, 1'b0);
        xact(1, 1'b0, 7'h08, 32'h0, 0, 1'b0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
